apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
Parametrised APB4 completer with a byte-strobed word memory behind it, configurable wait states and error signalling. It is the next-generation memory-mapped slave for our APB fabric and adds these features:
- generic data/address width and depth;
- registered pready with programmable wait insertion;
- PSLVERR on bad accesses;
- a clean abort when PSEL drops mid-transfer.

Parameters:
- DATA_W, 32: data bus width in bits; legal values 8/16/32/64.
- ADDR_W, 12: byte-address width of paddr.
- DEPTH, 256: number of DATA_W-bit words; must satisfy DEPTH <= 2^(ADDR_W - log2(DATA_W/8)).
- WAIT_STATES, 0: number of pready-low cycles inserted in each access phase; range 0..15.

Ports:
- pclk, input, 1: APB clock; all state changes on its rising edge.
- preset, input, 1: asynchronous, active-high reset.
- psel, input, 1: slave select.
- penable, input, 1: access phase indicator.
- pwrite, input, 1: 1 = write, 0 = read.
- paddr, input, ADDR_W: byte address.
- pwdata, input, DATA_W: write data.
- pstrb, input, DATA_W/8: write byte lanes.
- prdata, output, DATA_W: read data; registered.
- pready, output, 1: transfer complete; registered.
- pslverr, output, 1: transfer error; registered; meaningful only while pready=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pready=0, pslverr=0, prdata=0, wait counter=0. Memory contents are NOT reset (RAM-inferable); reads of unwritten words are undefined.
- Word index = paddr >> log2(DATA_W/8).
- An access is bad if any of these hold; the address and strobe checks are evaluated on entry to READY:
  - misaligned: paddr low log2(DATA_W/8) bits != 0;
  - out of range: word index >= DEPTH;
  - read with pstrb != 0.
- State machine has three states: IDLE, WAIT, READY.
- IDLE, pready=0:
  - psel=1 & penable=0 (setup phase) -> READY if WAIT_STATES==0, else WAIT with counter loaded with WAIT_STATES-1.
  - psel=1 & penable=1 without a preceding setup -> ignored; stay in IDLE.
- WAIT, pready=0:
  - psel=0 -> IDLE (abort, no memory change).
  - counter==0 -> READY.
  - otherwise decrement the counter.
- READY, pready=1 for exactly one cycle:
  - At the clock edge entering READY, prdata and pslverr are registered.
  - Good read: prdata <= mem[index], pslverr <= 0.
  - Bad read: prdata <= 0, pslverr <= 1.
  - Good write: pslverr <= 0, and prdata holds its previous value.
  - Bad write: pslverr <= 1.
- READY exit:
  - At the edge ending READY with psel=1 & penable=1, a good write commits: mem[index] byte lane i <= pwdata lane i for each pstrb[i]=1. pstrb=0 is a legal no-op write.
  - Bad writes never modify memory.
  - Next state is IDLE.
  - If psel=0 at the READY edge: abort, no write, IDLE.
- Latency: WAIT_STATES=0 gives a zero-wait APB transfer (2 cycles, setup + access); otherwise 2+WAIT_STATES cycles.
- pslverr is forced 0 whenever pready=0.
- prdata holds its last value between transfers.
- Back-to-back transfers: the setup phase of the next transfer is the cycle after READY and is accepted from IDLE, giving no dead cycle beyond the mandatory APB setup.
- Reset asserted mid-transfer: immediate IDLE, pready/pslverr=0; a pending write is dropped.
- Address, pwrite and pwdata are sampled at the cycle each is used; APB stability through setup and access is relied on.

Decomposition:
- Package apb_pkg:
  - typedef enum apb_slv_state_e {IDLE, WAIT, READY};
  - localparam function for log2 of byte lanes;
  - PSLVERR cause constants for bench coverage.
- Sub-module apb_sp_ram: DEPTH x DATA_W single-port RAM with per-byte write enables, async read, no reset. The FSM, error decode and wait counter stay in apb_mem_slave.

Test Plan:
- Defaults, zero-wait: write 0xDEADBEEF to 0x010 with pstrb=4'hF, then read 0x010 -> pready high in the first access cycle of each, prdata=0xDEADBEEF, pslverr=0.
- Byte strobes: write 0x11223344 to 0x020 (pstrb=F), then write 0xAABBCCDD with pstrb=4'b0101, read 0x020 -> prdata=0x11BB33DD.
- WAIT_STATES=3: read 0x004 -> pready low for 3 access cycles, high on the 4th; total 5 cycles from setup; pslverr=0.
- Errors:
  - read paddr=0x402 (misaligned) -> pslverr=1, prdata=0.
  - write paddr=0x400 (index 256 >= DEPTH) -> pslverr=1, and a later read of 0x000 is unchanged.
  - read with pstrb=4'h1 -> pslverr=1.
- Abort, WAIT_STATES=2: drop psel during the second wait cycle of a write to 0x030 -> FSM returns to IDLE, pready never asserts, and a later read shows the old data.
- Reset: assert preset asynchronously mid-access -> pready, pslverr and prdata go 0 immediately without a clock edge, and the next transfer after release completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory completer.
// Error cause bits let the error decode and the bench name the same fault classes.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_e;

  localparam logic [2:0] ERR_MISALIGNED = 3'b001;
  localparam logic [2:0] ERR_RANGE      = 3'b010;
  localparam logic [2:0] ERR_RD_STRB    = 3'b100;

  function automatic int lane_lg2(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_sp_ram.sv
// Single-port word RAM with per-byte write enables and asynchronous read.
// No reset so the array stays RAM-inferable.
module apb_sp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 completer in front of a byte-strobed word RAM with programmable wait
// states, PSLVERR on bad accesses and abort when psel drops mid-transfer.
//
// state | meaning
// IDLE  | no transfer; a setup phase starts one
// WAIT  | access phase, pready low, counting down inserted wait cycles
// READY | pready high for one cycle; a good write commits on the exit edge
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int LANE_LG = lane_lg2(DATA_W);
  localparam int WIDX_W  = ADDR_W - LANE_LG;
  localparam int RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LANE_LG) - 1);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  apb_slv_state_e    state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic [WIDX_W-1:0] widx;
  logic [2:0]        err_cause;
  logic              bad;
  logic              go_ready;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign widx = paddr[ADDR_W-1:LANE_LG];

  always_comb begin
    err_cause = '0;
    if ((paddr & ALIGN_MASK) != '0)       err_cause = err_cause | ERR_MISALIGNED;
    if (32'(widx) >= 32'(DEPTH))          err_cause = err_cause | ERR_RANGE;
    if (!pwrite && (pstrb != '0))         err_cause = err_cause | ERR_RD_STRB;
  end

  assign bad = |err_cause;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    ram_we    = 1'b0;
    go_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        // access phase without a setup phase is not a transfer
        if (psel && !penable) begin
          if (WAIT_STATES == 0) begin
            go_ready = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!psel)              state_d  = IDLE;
        else if (cnt_q == 4'd0) go_ready = 1'b1;
        else                    cnt_d    = cnt_q - 4'd1;
      end
      READY: begin
        state_d = IDLE;
        ram_we  = psel && penable && pwrite && !pslverr_q;
      end
      default: state_d = IDLE;
    endcase

    if (go_ready) begin
      state_d   = READY;
      pready_d  = 1'b1;
      pslverr_d = bad;
      if (!pwrite) prdata_d = bad ? '0 : ram_rdata;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (pclk),
    .we    (ram_we),
    .addr  (widx[RAM_AW-1:0]),
    .be    (pstrb),
    .wdata (pwdata),
    .rdata (ram_rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances with 0, 2 and 3 wait states share
// the APB bus, each selected by its own psel bit.
module tb_apb_mem_slave;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 256;

  logic        pclk = 1'b0;
  logic        preset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_w  [3];
  logic        pready_w  [3];
  logic        pslverr_w [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m   [3][DEPTH];
  logic [31:0] last_rd [3];

  always #5 pclk = ~pclk;

  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]));

  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]));

  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]));

  function automatic int ws_of(input int inst);
    case (inst)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  // Reference: an access is bad if misaligned, beyond DEPTH words, or a read with strobes.
  task automatic model_xfer(input int inst, input bit wr, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] exp_rd, output logic exp_err);
    int  idx;
    bit  is_bad;
    idx    = int'(addr) / 4;
    is_bad = (int'(addr) % 4 != 0) || (idx >= DEPTH) || (!wr && st != 4'h0);
    exp_err = is_bad;
    if (wr) begin
      if (!is_bad) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) mem_m[inst][idx][b*8 +: 8] = wd[b*8 +: 8];
      end
    end else begin
      last_rd[inst] = is_bad ? 32'h0 : mem_m[inst][idx];
    end
    exp_rd = last_rd[inst];
  endtask

  // Drives one full transfer starting in the current cycle; cycles counts setup..ready inclusive.
  task automatic xfer(input int inst, input bit wr, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic err,
                      output int cycles, output bit err_low);
    psel       = 3'b000;
    psel[inst] = 1'b1;
    penable    = 1'b0;
    pwrite     = wr;
    paddr      = addr;
    pwdata     = wd;
    pstrb      = st;
    err_low    = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    cycles  = 2;
    while (pready_w[inst] !== 1'b1 && cycles < 40) begin
      if (pslverr_w[inst] !== 1'b0) err_low = 1'b1;
      @(posedge pclk); #1;
      cycles++;
    end
    rd  = prdata_w[inst];
    err = pslverr_w[inst];
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
    end
  endtask

  task automatic test_reset();
    preset  = 1'b1;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pready_w[i] !== 1'b0) begin n_bad++; $display("FAIL reset_pready[%0d]: got %b want 0", i, pready_w[i]); end
      n_cmp++; if (pslverr_w[i] !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr[%0d]: got %b want 0", i, pslverr_w[i]); end
      n_cmp++; if (prdata_w[i] !== 32'h0) begin n_bad++; $display("FAIL reset_prdata[%0d]: got %h want 0", i, prdata_w[i]); end
    end
    preset = 1'b0;
    idle(1);
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic err; int cyc; bit el;
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, err, cyc, el);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL zw_wr_cycles: got %0d want 2", cyc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL zw_wr_err: got %b want 0", err); end
    idle(1);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL zw_rd_cycles: got %0d want 2", cyc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL zw_rd_err: got %b want 0", err); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL zw_rd_data: got %h want deadbeef", rd); end
    idle(1);
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err; int cyc; bit el;
    xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, rd, err, cyc, el);
    xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, rd, err, cyc, el);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL strb_wr_err: got %b want 0", err); end
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL strb_rd_data: got %h want 11bb33dd", rd); end
    idle(1);
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int cyc; bit el;
    xfer(2, 1'b1, 12'h004, 32'h0BADF00D, 4'hF, rd, err, cyc, el);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL ws3_wr_cycles: got %0d want 5", cyc); end
    idle(1);
    xfer(2, 1'b0, 12'h004, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL ws3_rd_cycles: got %0d want 5", cyc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ws3_rd_err: got %b want 0", err); end
    n_cmp++; if (el !== 1'b0) begin n_bad++; $display("FAIL ws3_err_while_low: got %b want 0", el); end
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL ws3_rd_data: got %h want 0badf00d", rd); end
    idle(1);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc; bit el;
    xfer(0, 1'b1, 12'h000, 32'h5A5A1234, 4'hF, rd, err, cyc, el);
    xfer(0, 1'b0, 12'h402, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_misalign_rd: got %b want 1", err); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL err_misalign_rdata: got %h want 0", rd); end
    xfer(0, 1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, rd, err, cyc, el);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_range_wr: got %b want 1", err); end
    xfer(0, 1'b1, 12'h001, 32'hFFFFFFFF, 4'hF, rd, err, cyc, el);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_misalign_wr: got %b want 1", err); end
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_after_rd_err: got %b want 0", err); end
    n_cmp++; if (rd !== 32'h5A5A1234) begin n_bad++; $display("FAIL err_mem_unchanged: got %h want 5a5a1234", rd); end
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h1, rd, err, cyc, el);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_rd_strb: got %b want 1", err); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL err_rd_strb_data: got %h want 0", rd); end
    idle(1);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc; bit el; bit seen_ready;
    xfer(1, 1'b1, 12'h030, 32'h01234567, 4'hF, rd, err, cyc, el);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL abort_pre_cycles: got %0d want 4", cyc); end
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h030; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    n_cmp++; if (pready_w[1] !== 1'b0) begin n_bad++; $display("FAIL abort_wait1_pready: got %b want 0", pready_w[1]); end
    @(posedge pclk); #1;
    n_cmp++; if (pready_w[1] !== 1'b0) begin n_bad++; $display("FAIL abort_wait2_pready: got %b want 0", pready_w[1]); end
    psel = 3'b000; penable = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      if (pready_w[1] !== 1'b0) seen_ready = 1'b1;
    end
    n_cmp++; if (seen_ready !== 1'b0) begin n_bad++; $display("FAIL abort_pready_seen: got %b want 0", seen_ready); end
    xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (rd !== 32'h01234567) begin n_bad++; $display("FAIL abort_old_data: got %h want 01234567", rd); end
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL abort_rd_cycles: got %0d want 4", cyc); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int cyc; bit el; time t0;
    t0 = $time;
    xfer(0, 1'b1, 12'h040, 32'hCAFE0001, 4'hF, rd, err, cyc, el);
    xfer(0, 1'b1, 12'h044, 32'hCAFE0002, 4'hF, rd, err, cyc, el);
    xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (rd !== 32'hCAFE0001) begin n_bad++; $display("FAIL b2b_rd0: got %h want cafe0001", rd); end
    xfer(0, 1'b0, 12'h044, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (rd !== 32'hCAFE0002) begin n_bad++; $display("FAIL b2b_rd1: got %h want cafe0002", rd); end
    n_cmp++; if ($time - t0 !== 80) begin n_bad++; $display("FAIL b2b_total_time: got %0t want 80", $time - t0); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc; bit el;
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, cyc, el);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h010; pwdata = 32'h00000000; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    n_cmp++; if (pready_w[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_pready: got %b want 1", pready_w[0]); end
    #2 preset = 1'b1;
    #1;
    n_cmp++; if (pready_w[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_pready: got %b want 0", pready_w[0]); end
    n_cmp++; if (pslverr_w[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_pslverr: got %b want 0", pslverr_w[0]); end
    n_cmp++; if (prdata_w[0] !== 32'h0) begin n_bad++; $display("FAIL rstmid_prdata: got %h want 0", prdata_w[0]); end
    psel = 3'b000; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    idle(1);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, cyc, el);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rstmid_write_dropped: got %h want deadbeef", rd); end
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL rstmid_next_cycles: got %0d want 2", cyc); end
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, wd; logic err, exp_err; int cyc; bit el;
    int inst, kind; bit wr; logic [11:0] addr; logic [3:0] st;
    preset = 1'b1;
    idle(1);
    preset = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 64; w++) begin
        wd = $urandom;
        model_xfer(i, 1'b1, 12'(w * 4), wd, 4'hF, exp_rd, exp_err);
        xfer(i, 1'b1, 12'(w * 4), wd, 4'hF, rd, err, cyc, el);
      end
    end
    for (int n = 0; n < 150; n++) begin
      inst = $urandom_range(0, 2);
      wr   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind == 0)      addr = 12'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (kind == 1) addr = 12'(12'h400 + $urandom_range(0, 767) * 4);
      else                addr = 12'($urandom_range(0, 63) * 4);
      wd = $urandom;
      if (wr) st = 4'($urandom_range(0, 15));
      else    st = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      model_xfer(inst, wr, addr, wd, st, exp_rd, exp_err);
      xfer(inst, wr, addr, wd, st, rd, err, cyc, el);
      n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL rnd_err #%0d i%0d wr%0b a%h: got %b want %b", n, inst, wr, addr, err, exp_err); end
      n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd_prdata #%0d i%0d wr%0b a%h: got %h want %h", n, inst, wr, addr, rd, exp_rd); end
      n_cmp++; if (cyc !== 2 + ws_of(inst)) begin n_bad++; $display("FAIL rnd_cycles #%0d i%0d: got %0d want %0d", n, inst, cyc, 2 + ws_of(inst)); end
      n_cmp++; if (el !== 1'b0) begin n_bad++; $display("FAIL rnd_err_while_low #%0d i%0d: got %b want 0", n, inst, el); end
      if ($urandom_range(0, 1) == 0) idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_strobes();
    test_wait_states();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
